// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner:
// debounce states, per-scan result encoding and the key label map.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_CAND,
    ST_PRESSED,
    ST_REL_CAND
  } deb_state_e;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_KEY,
    RES_MULTI
  } scan_kind_e;

  typedef struct packed {
    logic       valid;
    scan_kind_e kind;
    logic [3:0] code;
  } scan_result_t;

  // Indexed {row, col}; element 0 is the top-left key.
  localparam logic [15:0][3:0] KEYMAP = {
    4'hD, 4'hE, 4'hF, 4'h0,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  // Hit counts only need to distinguish zero, one and "more than one".
  function automatic logic [1:0] hits_sat(input logic [2:0] n);
    return (n >= 3'd2) ? 2'd2 : n[1:0];
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side pins and the decoded key outputs of the scanner.
interface keypad_scanner_if;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (output col, key_code, key_valid, key_held, input row);
  modport slave  (input col, key_code, key_valid, key_held, output row);
endinterface

// File: rtl/keypad_debounce.sv
// Press/release debounce FSM consuming one scan result per full keypad scan
// and producing the held key code, a one-cycle accept strobe and a held flag.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  scan_result_t result,
  output logic [3:0]   key_code,
  output logic         key_valid,
  output logic         key_held
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

  deb_state_e       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [3:0]       cand, cand_next;
  logic [3:0]       code_next;
  logic             valid_next, held_next;
  logic             is_key;

  // NOTE: every comb output gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cand_next  = cand;
    code_next  = key_code;
    held_next  = key_held;
    valid_next = 1'b0;
    is_key     = (result.kind == RES_KEY);

    if (result.valid) begin
      unique case (state)
        ST_IDLE: begin
          if (is_key) begin
            cand_next = result.code;
            cnt_next  = CNT_ONE;
            if (CNT_ONE == CNT_DONE) begin
              state_next = ST_PRESSED;
              code_next  = result.code;
              valid_next = 1'b1;
              held_next  = 1'b1;
            end else begin
              state_next = ST_PRESS_CAND;
            end
          end
        end
        ST_PRESS_CAND: begin
          if (is_key && result.code == cand) begin
            cnt_next = cnt + CNT_ONE;
            if (cnt_next == CNT_DONE) begin
              state_next = ST_PRESSED;
              code_next  = cand;
              valid_next = 1'b1;
              held_next  = 1'b1;
            end
          end else if (is_key) begin
            cand_next = result.code;
            cnt_next  = CNT_ONE;
          end else begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end
        end
        ST_PRESSED: begin
          if (!(is_key && result.code == key_code)) begin
            if (CNT_ONE == CNT_DONE) begin
              state_next = ST_IDLE;
              cnt_next   = '0;
              held_next  = 1'b0;
            end else begin
              state_next = ST_REL_CAND;
              cnt_next   = CNT_ONE;
            end
          end
        end
        ST_REL_CAND: begin
          if (is_key && result.code == key_code) begin
            state_next = ST_PRESSED;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_ONE;
            if (cnt_next == CNT_DONE) begin
              state_next = ST_IDLE;
              cnt_next   = '0;
              held_next  = 1'b0;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cand      <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      cand      <= cand_next;
      key_code  <= code_next;
      key_valid <= valid_next;
      key_held  <= held_next;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotates an active-low column strobe, samples the
// synchronized rows per column and classifies each full scan for debounce.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input logic              clk,
  input logic              clr,
  keypad_scanner_if.master kp
);
  import keypad_pkg::*;

  localparam int DIV_W = $clog2(SCAN_DIV);

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       col_idx;
  logic [3:0]       row_meta, row_sync;
  logic [1:0]       acc_hits;
  logic [3:0]       acc_code;
  logic             sample;
  logic [3:0]       lows;
  logic [2:0]       hits_now;
  logic [1:0]       row_idx;
  logic [1:0]       total_hits;
  logic [3:0]       merged_code;
  scan_result_t     result;

  assign sample = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign kp.col = ~(4'b0001 << col_idx);

  // Rows come straight from mechanical switches, unrelated to clk.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      row_meta <= 4'b1111;
      row_sync <= 4'b1111;
    end else begin
      row_meta <= kp.row;
      row_sync <= row_meta;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      div_cnt <= '0;
      col_idx <= 2'd0;
    end else if (sample) begin
      div_cnt <= '0;
      col_idx <= col_idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_comb begin
    lows     = ~row_sync;
    hits_now = 3'd0;
    row_idx  = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      hits_now = hits_now + {2'b00, lows[r]};
      if (lows[r]) row_idx = 2'(r);
    end
    total_hits  = hits_sat({1'b0, acc_hits} + hits_now);
    merged_code = (hits_now == 3'd1) ? KEYMAP[{row_idx, col_idx}] : acc_code;

    result.valid = sample && (col_idx == 2'd3);
    result.code  = merged_code;
    result.kind  = (total_hits == 2'd0) ? RES_NONE :
                   (total_hits == 2'd1) ? RES_KEY  : RES_MULTI;
  end

  // The column-3 sample closes the scan, so the accumulator restarts there.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      acc_hits <= 2'd0;
      acc_code <= 4'h0;
    end else if (sample) begin
      if (col_idx == 2'd3) begin
        acc_hits <= 2'd0;
        acc_code <= 4'h0;
      end else begin
        acc_hits <= total_hits;
        acc_code <= merged_code;
      end
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk      (clk),
    .clr      (clr),
    .result   (result),
    .key_code (kp.key_code),
    .key_valid(kp.key_valid),
    .key_held (kp.key_held)
  );

endmodule
